hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage RV32IC core.
- Sits beside the forwarding logic and drives the write-enable, flush and freeze controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Covers four cases: load-use bubble insertion, taken-branch flush, whole-pipe freeze while the data memory is busy, and a stall watchdog.
- Deferred branch flushes are held across a freeze.

Parameters:
- MAX_WAIT, 255: freeze cycles allowed before the watchdog fires.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  asynchronous reset, active-low
- RS1addr_ID_i  input  5  rs1 of the instruction in ID
- RS2addr_ID_i  input  5  rs2 of the instruction in ID
- RS1use_i  input  1  instruction in ID reads rs1
- RS2use_i  input  1  instruction in ID reads rs2
- RDaddr_IDEX_i  input  5  rd of the instruction in EX
- MemRead_IDEX_i  input  1  instruction in EX is a load
- BranchTaken_i  input  1  branch resolved taken in ID
- DmemStall_i  input  1  data memory busy; level signal
- PCWrite_o  output  1  PC update enable
- IFIDWrite_o  output  1  IF/ID write enable
- IFIDFlush_o  output  1  IF/ID becomes NOP
- IDEXFlush_o  output  1  ID/EX control bits zeroed (bubble)
- PipeFreeze_o  output  1  hold EX/MEM and MEM/WB
- Timeout_o  output  1  sticky watchdog flag

Behaviour:
- States: RUN, FREEZE. Registers: state, flush_pend, wait_cnt[CNT_W-1:0], Timeout_o.
- Outputs are combinational from the registers and the current inputs. There is no added latency.
- Reset (rst_i low, async): state=RUN, flush_pend=0, wait_cnt=0, Timeout_o=0.
- Reset output values (inputs 0): PCWrite_o=1, IFIDWrite_o=1, all flush and freeze outputs 0.
- Reset asserted mid-freeze drops all state immediately. A pending flush is discarded.
- lu_hazard = MemRead_IDEX_i & (RDaddr_IDEX_i != 0) & ((RS1use_i & RDaddr_IDEX_i == RS1addr_ID_i) | (RS2use_i & RDaddr_IDEX_i == RS2addr_ID_i)).
- Priority: DmemStall_i, then lu_hazard, then branch flush.
- RUN with DmemStall_i=1:
  - PCWrite_o=0, IFIDWrite_o=0, PipeFreeze_o=1, IFIDFlush_o=0, IDEXFlush_o=0.
  - flush_pend <= BranchTaken_i. wait_cnt <= 1. Next state FREEZE.
- RUN with DmemStall_i=0 and lu_hazard=1:
  - PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1, IFIDFlush_o=0.
  - BranchTaken_i is ignored; the branch re-resolves next cycle.
  - Stay in RUN. Exactly one bubble, because the bubble clears MemRead in EX.
- RUN, neither stall condition:
  - PCWrite_o=1, IFIDWrite_o=1.
  - IFIDFlush_o = BranchTaken_i | flush_pend. flush_pend <= 0.
- FREEZE with DmemStall_i=1:
  - Freeze outputs as above. flush_pend <= flush_pend | BranchTaken_i.
  - wait_cnt increments and saturates at 2^CNT_W-1.
  - When wait_cnt reaches MAX_WAIT and DmemStall_i is still 1: Timeout_o <= 1. It is sticky until reset.
- FREEZE with DmemStall_i=0:
  - This cycle behaves as RUN with no stall: flush applied if flush_pend or BranchTaken_i.
  - state <= RUN, wait_cnt <= 0, flush_pend <= 0.
  - lu_hazard in this cycle is evaluated as in RUN and takes priority over the flush; flush_pend is then retained.
- rd=x0 never causes a stall.
- Back-to-back DmemStall_i pulses re-enter FREEZE with wait_cnt restarting at 1.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, two extra output ports are added, both reset to 0, both wrapping at 2^32:
  - StallCycles_o (32): increments every cycle PipeFreeze_o=1.
  - BubbleCnt_o (32): increments every cycle IDEXFlush_o=1.
- When undefined, neither port nor any counter logic exists. All other behaviour is identical.

Test Plan:
- Load-use: EX is lw with rd=5, ID uses rs1=5 with RS1use_i=1 -> one cycle of PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1; the next cycle (MemRead=0) is normal.
- rd=0, or rs2 match with RS2use_i=0 -> no stall; all enables stay 1.
- Branch taken in RUN, no hazard -> IFIDFlush_o=1 for exactly one cycle, PCWrite_o=1.
- DmemStall_i high for 3 cycles with BranchTaken_i high in freeze cycle 2 -> PipeFreeze_o=1 for 3 cycles with no flush; on the release cycle IFIDFlush_o=1, then flush_pend=0.
- MAX_WAIT=4, DmemStall_i held for 6 cycles -> Timeout_o rises after the 4th freeze cycle and stays 1 after release; async rst_i low clears it at once.
- Assert rst_i mid-FREEZE with flush_pend=1 -> outputs immediately PCWrite_o=1, PipeFreeze_o=0; no flush after reset release.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: PC / pipeline-register sequencing for the 5-stage core.
// Handles load-use bubbles, taken-branch flushes, whole-pipe freeze on a busy
// data memory (branch flushes raised during a freeze are deferred to release)
// and a sticky watchdog on long freezes.
// Optional build macro: HAZARD_PERF_CNT_EN adds StallCycles_o / BubbleCnt_o.
//
// state  | meaning
// RUN    | pipe advancing; bubbles and flushes applied combinationally
// FREEZE | data memory busy; PC and all pipe registers held, watchdog counting
module hazard_stall_controller #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] RS1addr_ID_i,
    input  logic [4:0] RS2addr_ID_i,
    input  logic       RS1use_i,
    input  logic       RS2use_i,
    input  logic [4:0] RDaddr_IDEX_i,
    input  logic       MemRead_IDEX_i,
    input  logic       BranchTaken_i,
    input  logic       DmemStall_i,
    output logic       PCWrite_o,
    output logic       IFIDWrite_o,
    output logic       IFIDFlush_o,
    output logic       IDEXFlush_o,
    output logic       PipeFreeze_o,
    output logic       Timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles_o,
    output logic [31:0] BubbleCnt_o
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } stateT;

    localparam logic [CNT_W-1:0] MaxWaitC = CNT_W'(MAX_WAIT);

    stateT            state;
    stateT            stateNext;
    logic             flushPend;
    logic             flushPendNext;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic [CNT_W-1:0] cntInc;
    logic             timeoutNext;
    logic             luHazard;

    // Load in EX writing a register the instruction in ID actually reads; x0 never stalls.
    always_comb begin
        luHazard = MemRead_IDEX_i && (RDaddr_IDEX_i != 5'd0) &&
                   ((RS1use_i && (RDaddr_IDEX_i == RS1addr_ID_i)) ||
                    (RS2use_i && (RDaddr_IDEX_i == RS2addr_ID_i)));
    end

    // Saturating increment of the freeze-length counter.
    always_comb begin
        cntInc = (waitCnt == {CNT_W{1'b1}}) ? waitCnt : waitCnt + CNT_W'(1);
    end

    // Next-state and output decode; priority is freeze, then bubble, then flush.
    always_comb begin
        stateNext     = state;
        flushPendNext = flushPend;
        waitCntNext   = waitCnt;
        timeoutNext   = Timeout_o;
        PCWrite_o     = 1'b1;
        IFIDWrite_o   = 1'b1;
        IFIDFlush_o   = 1'b0;
        IDEXFlush_o   = 1'b0;
        PipeFreeze_o  = 1'b0;

        if (DmemStall_i) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            PipeFreeze_o = 1'b1;
            stateNext    = FREEZE;
            if (state == RUN) begin
                flushPendNext = BranchTaken_i;
                waitCntNext   = CNT_W'(1);
            end else begin
                flushPendNext = flushPend | BranchTaken_i;
                waitCntNext   = cntInc;
            end
            // waitCntNext counts freeze cycles completed including this one.
            if (waitCntNext >= MaxWaitC) begin
                timeoutNext = 1'b1;
            end
        end else begin
            stateNext   = RUN;
            waitCntNext = '0;
            if (luHazard) begin
                // Branch re-resolves after the bubble; any deferred flush is kept.
                PCWrite_o   = 1'b0;
                IFIDWrite_o = 1'b0;
                IDEXFlush_o = 1'b1;
            end else begin
                IFIDFlush_o   = BranchTaken_i | flushPend;
                flushPendNext = 1'b0;
            end
        end
    end

    // State, deferred-flush, watchdog counter and sticky timeout registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= RUN;
            flushPend <= 1'b0;
            waitCnt   <= '0;
            Timeout_o <= 1'b0;
        end else begin
            state     <= stateNext;
            flushPend <= flushPendNext;
            waitCnt   <= waitCntNext;
            Timeout_o <= timeoutNext;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running performance counters for freeze cycles and inserted bubbles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            StallCycles_o <= '0;
            BubbleCnt_o   <= '0;
        end else begin
            if (PipeFreeze_o) begin
                StallCycles_o <= StallCycles_o + 32'd1;
            end
            if (IDEXFlush_o) begin
                BubbleCnt_o <= BubbleCnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
